// File: rtl/led_pattern_engine_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : led_pkg
//  Description : Shared types and helpers for the LED pattern engine:
//                mode and state encodings, and the alternating-bit pattern
//                generator used for the green and sweep frames.
//  Revision    : 1.0 - initial release
// ============================================================================
package led_pkg;

    // Mode request as driven on the enable input
    typedef enum logic [1:0] {
        MODE_OFF   = 2'b00,
        MODE_CHASE = 2'b01,
        MODE_FLASH = 2'b10,
        MODE_SWEEP = 2'b11
    } mode_t;

    // Sequencer state
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHASE = 3'd1,
        ST_FLASH = 3'd2,
        ST_SWEEP = 3'd3,
        ST_HOLD  = 3'd4
    } state_t;

    // Widest bank the alternating-pattern helper can build
    localparam int c_MAX_W = 64;

    // Returns 1010... right-aligned in a c_MAX_W vector, with bit width-1 set
    function automatic logic [c_MAX_W-1:0] alt_pattern(input int width);
        logic [c_MAX_W-1:0] v;
        v = '0;
        for (int i = 0; i < c_MAX_W; i++) begin
            if ((i < width) && (((width - 1 - i) % 2) == 0)) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_pattern_engine_if.sv
`default_nettype none
// ============================================================================
//  Module      : led_pattern_engine_if
//  Description : Connection between the alarm controller (master) and the
//                LED pattern engine (slave): mode request in, LED banks and
//                status out.
//  Revision    : 1.0 - initial release
// ============================================================================
interface led_pattern_engine_if #(
    parameter int RED_W   = 18,
    parameter int GREEN_W = 9
);
    logic [1:0]         enable;
    logic [RED_W-1:0]   ledr;
    logic [GREEN_W-1:0] ledg;
    logic               busy;
    logic               done;

    modport master (output enable, input ledr, input ledg, input busy, input done);
    modport slave  (input enable, output ledr, output ledg, output busy, output done);
endinterface
`default_nettype wire

// File: rtl/led_pattern_engine_step_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : led_step_prescaler
//  Description : Divides clk into one-cycle animation step strobes, one every
//                TICK_DIV cycles. clear restarts the division so a new
//                pattern always shows its first frame for a full step.
//  Revision    : 1.0 - initial release
// ============================================================================
module led_step_prescaler #(
    parameter int TICK_DIV = 1
) (
    input  wire  clk,
    input  wire  reset,
    input  wire  clear,
    output logic step
);
    localparam int                 c_CNT_W = $clog2(TICK_DIV + 1);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(TICK_DIV - 1);

    logic [c_CNT_W-1:0] r_cnt;

    // Count 0..TICK_DIV-1 and wrap; clear and reset both restart at 0
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_cnt <= '0;
        end else if (r_cnt == c_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign step = (r_cnt == c_LAST);
endmodule
`default_nettype wire

// File: rtl/led_pattern_engine.sv
`default_nettype none
// ============================================================================
//  Module      : led_pattern_engine
//  Description : Car-alarm LED sequencer. Selects bounce-chase, burst-flash
//                or alternate-sweep by mode, with step prescaler, finite
//                burst termination (busy/done) and restart on mode change.
//                Optional build macro LED_DIM_EN: 50% PWM dimming of lit LEDs.
//  Revision    : 1.0 - initial release
// ============================================================================
module led_pattern_engine
    import led_pkg::*;
#(
    parameter int RED_W       = 18,
    parameter int GREEN_W     = 9,
    parameter int TICK_DIV    = 1,
    parameter int FLASH_COUNT = 3,
    parameter int SWEEP_STEPS = 11
) (
    input wire clk,
    input wire reset,
    led_pattern_engine_if.slave bus
);
    localparam int H       = RED_W / 2;
    localparam int POS_W   = $clog2(H - 2 + 1);
    localparam int FLASH_W = $clog2(FLASH_COUNT + 1);
    localparam int SWEEP_W = $clog2(SWEEP_STEPS + 1);

    localparam logic [POS_W-1:0]   c_POS_INIT   = POS_W'(H - 2);
    localparam logic [POS_W-1:0]   c_POS_TURN   = POS_W'(H - 3);
    localparam logic [FLASH_W-1:0] c_FLASH_LAST = FLASH_W'(FLASH_COUNT);
    localparam logic [SWEEP_W-1:0] c_SWEEP_LAST = SWEEP_W'(SWEEP_STEPS - 1);

    localparam logic [c_MAX_W-1:0] c_ALT_R_FULL = alt_pattern(RED_W);
    localparam logic [c_MAX_W-1:0] c_ALT_G_FULL = alt_pattern(GREEN_W);
    localparam logic [RED_W-1:0]   c_ALT_R      = c_ALT_R_FULL[RED_W-1:0];
    localparam logic [GREEN_W-1:0] c_ALT_G      = c_ALT_G_FULL[GREEN_W-1:0];

    // Low half holds the pair at [pos+1:pos]; upper half is its mirror image
    function automatic logic [RED_W-1:0] chase_frame(input logic [POS_W-1:0] pos);
        logic [H-1:0]     low;
        logic [RED_W-1:0] f;
        low = {{(H-2){1'b0}}, 2'b11} << pos;
        f   = '0;
        for (int j = 0; j < H; j++) begin
            f[j]     = low[j];
            f[H + j] = low[H - 1 - j];
        end
        return f;
    endfunction

    logic [1:0]         r_mode;
    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_change;
    logic               w_step;
    logic [POS_W-1:0]   r_pos,   w_pos_nxt;
    logic               r_dir,   w_dir_nxt;     // 0: pair moves right, 1: left
    logic [FLASH_W-1:0] r_phase, w_phase_nxt;   // on-phases emitted so far
    logic               r_on,    w_on_nxt;
    logic [SWEEP_W-1:0] r_steps, w_steps_nxt;
    logic [RED_W-1:0]   r_ledr,  w_ledr_nxt;
    logic [GREEN_W-1:0] r_ledg,  w_ledg_nxt;
    logic               r_done,  w_done_nxt;
    logic               w_busy;

    assign w_change = (bus.enable != r_mode);

    led_step_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clear (w_change),
        .step  (w_step)
    );

    // Track the last requested mode to detect changes
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mode <= 2'b00;
        end else begin
            r_mode <= bus.enable;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: mode change wins; finite patterns end into HOLD on a step
    always_comb begin
        w_state_nxt = r_state;
        if (w_change) begin
            case (mode_t'(bus.enable))
                MODE_CHASE: w_state_nxt = ST_CHASE;
                MODE_FLASH: w_state_nxt = ST_FLASH;
                MODE_SWEEP: w_state_nxt = ST_SWEEP;
                default:    w_state_nxt = ST_IDLE;
            endcase
        end else if (w_step) begin
            case (r_state)
                ST_FLASH: if (r_on && (r_phase == c_FLASH_LAST)) w_state_nxt = ST_HOLD;
                ST_SWEEP: if (r_steps == c_SWEEP_LAST)           w_state_nxt = ST_HOLD;
                default:  w_state_nxt = r_state;
            endcase
        end
    end

    // Outputs: next frame, counter updates and status for the coming cycle
    always_comb begin
        w_pos_nxt   = r_pos;
        w_dir_nxt   = r_dir;
        w_phase_nxt = r_phase;
        w_on_nxt    = r_on;
        w_steps_nxt = r_steps;
        w_ledr_nxt  = r_ledr;
        w_ledg_nxt  = r_ledg;
        w_done_nxt  = (w_state_nxt == ST_HOLD) && (r_state != ST_HOLD);
        w_busy      = (r_state == ST_CHASE) || (r_state == ST_FLASH) || (r_state == ST_SWEEP);
        if (w_change) begin
            w_pos_nxt   = c_POS_INIT;
            w_dir_nxt   = 1'b0;
            w_phase_nxt = FLASH_W'(1);
            w_on_nxt    = 1'b1;
            w_steps_nxt = '0;
            case (w_state_nxt)
                ST_CHASE: begin
                    w_ledr_nxt = chase_frame(c_POS_INIT);
                    w_ledg_nxt = c_ALT_G;
                end
                ST_FLASH: begin
                    w_ledr_nxt = '1;
                    w_ledg_nxt = '1;
                end
                ST_SWEEP: begin
                    w_ledr_nxt = c_ALT_R;
                    w_ledg_nxt = c_ALT_R[GREEN_W-1:0];
                end
                default: begin
                    w_ledr_nxt = '0;
                    w_ledg_nxt = '0;
                end
            endcase
        end else if (w_step) begin
            case (r_state)
                ST_CHASE: begin
                    // Direction flips on the step that lands on an end position
                    if (!r_dir) begin
                        w_pos_nxt = r_pos - 1'b1;
                        if (r_pos == POS_W'(1)) w_dir_nxt = 1'b1;
                    end else begin
                        w_pos_nxt = r_pos + 1'b1;
                        if (r_pos == c_POS_TURN) w_dir_nxt = 1'b0;
                    end
                    w_ledr_nxt = chase_frame(w_pos_nxt);
                    w_ledg_nxt = ~r_ledg;
                end
                ST_FLASH: begin
                    if (w_state_nxt == ST_HOLD || r_on) begin
                        w_on_nxt   = 1'b0;
                        w_ledr_nxt = '0;
                        w_ledg_nxt = '0;
                    end else begin
                        w_on_nxt    = 1'b1;
                        w_phase_nxt = r_phase + 1'b1;
                        w_ledr_nxt  = '1;
                        w_ledg_nxt  = '1;
                    end
                end
                ST_SWEEP: begin
                    if (w_state_nxt == ST_HOLD) begin
                        w_ledr_nxt = '0;
                        w_ledg_nxt = '0;
                    end else begin
                        w_steps_nxt = r_steps + 1'b1;
                        w_ledr_nxt  = ~r_ledr;
                        w_ledg_nxt  = ~r_ledg;
                    end
                end
                default: begin
                    w_ledr_nxt = '0;
                    w_ledg_nxt = '0;
                end
            endcase
        end
    end

    // Pattern and counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pos   <= '0;
            r_dir   <= 1'b0;
            r_phase <= '0;
            r_on    <= 1'b0;
            r_steps <= '0;
            r_ledr  <= '0;
            r_ledg  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_pos   <= w_pos_nxt;
            r_dir   <= w_dir_nxt;
            r_phase <= w_phase_nxt;
            r_on    <= w_on_nxt;
            r_steps <= w_steps_nxt;
            r_ledr  <= w_ledr_nxt;
            r_ledg  <= w_ledg_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign bus.busy = w_busy;
    assign bus.done = r_done;

`ifdef LED_DIM_EN
    logic [2:0] r_pwm;

    // Free-running PWM phase; lit LEDs are driven only in phases 0..3
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pwm <= 3'd0;
        end else begin
            r_pwm <= r_pwm + 3'd1;
        end
    end

    assign bus.ledr = r_pwm[2] ? '0 : r_ledr;
    assign bus.ledg = r_pwm[2] ? '0 : r_ledg;
`else
    assign bus.ledr = r_ledr;
    assign bus.ledg = r_ledg;
`endif

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_led_pattern_engine
//  Description : Scoreboard bench for led_pattern_engine. One instance uses a
//                step every clk with SWEEP_STEPS=4, a second uses TICK_DIV=4.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_led_pattern_engine;

    typedef struct packed {
        logic        sel;   // 0: fast instance, 1: divided instance
        logic [17:0] r;
        logic [8:0]  g;
        logic        b;
        logic        d;
    } exp_t;

    logic  clk;
    logic  reset;
    exp_t  exp_q[$];
    string name_q[$];
    int    n_vec;
    int    n_miss;

    logic [17:0] chase_tab [0:7] = '{18'h30003, 18'h18006, 18'h0C00C, 18'h06018,
                                     18'h03030, 18'h01860, 18'h00CC0, 18'h00780};

    led_pattern_engine_if #(.RED_W(18), .GREEN_W(9)) if0 ();
    led_pattern_engine_if #(.RED_W(18), .GREEN_W(9)) if1 ();

    led_pattern_engine #(
        .RED_W(18), .GREEN_W(9), .TICK_DIV(1), .FLASH_COUNT(3), .SWEEP_STEPS(4)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (if0)
    );

    led_pattern_engine #(
        .RED_W(18), .GREEN_W(9), .TICK_DIV(4), .FLASH_COUNT(3), .SWEEP_STEPS(4)
    ) u_dut_div (
        .clk   (clk),
        .reset (reset),
        .bus   (if1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle of stimulus and queue the outputs expected after the next edge
    task automatic cyc(input logic rst_v, input logic [1:0] e0, input logic [1:0] e1,
                       input logic sel, input logic [17:0] r, input logic [8:0] g,
                       input logic b, input logic d, input string nm);
        exp_t e;
        @(negedge clk);
        reset      = rst_v;
        if0.enable = e0;
        if1.enable = e1;
        e = '{sel: sel, r: r, g: g, b: b, d: d};
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Monitor: every cycle with a pending expectation is compared
    initial begin
        exp_t        e;
        string       nm;
        logic [17:0] ar;
        logic [8:0]  ag;
        logic        ab;
        logic        ad;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if (e.sel) begin
                    ar = if1.ledr; ag = if1.ledg; ab = if1.busy; ad = if1.done;
                end else begin
                    ar = if0.ledr; ag = if0.ledg; ab = if0.busy; ad = if0.done;
                end
                n_vec++;
                if ({ar, ag, ab, ad} !== {e.r, e.g, e.b, e.d}) begin
                    n_miss++;
                    $display("FAIL %s: got ledr=%05h ledg=%03h busy=%b done=%b, want ledr=%05h ledg=%03h busy=%b done=%b",
                             nm, ar, ag, ab, ad, e.r, e.g, e.b, e.d);
                end
            end
        end
    end

    initial begin
        int p;
        n_vec      = 0;
        n_miss     = 0;
        reset      = 1'b1;
        if0.enable = 2'b01;
        if1.enable = 2'b00;

        // Reset held with CHASE requested, then first chase frame
        for (int i = 0; i < 3; i++) cyc(1, 2'b01, 2'b00, 0, 18'h0, 9'h0, 0, 0, "reset");
        cyc(0, 2'b01, 2'b00, 0, 18'h00780, 9'h155, 1, 0, "chase_first");

        // 14 chase steps: pair runs to [1:0] and bounces back to [8:7]
        for (int k = 1; k <= 14; k++) begin
            p = (k <= 7) ? (7 - k) : (k - 7);
            cyc(0, 2'b01, 2'b00, 0, chase_tab[p], (k % 2 == 1) ? 9'h0AA : 9'h155, 1, 0,
                $sformatf("chase_s%0d", k));
        end

        // IDLE, then a full FLASH burst ending in HOLD
        cyc(0, 2'b00, 2'b00, 0, 18'h0,     9'h0,   0, 0, "idle");
        cyc(0, 2'b10, 2'b00, 0, 18'h3FFFF, 9'h1FF, 1, 0, "flash_on1");
        cyc(0, 2'b10, 2'b00, 0, 18'h0,     9'h0,   1, 0, "flash_off1");
        cyc(0, 2'b10, 2'b00, 0, 18'h3FFFF, 9'h1FF, 1, 0, "flash_on2");
        cyc(0, 2'b10, 2'b00, 0, 18'h0,     9'h0,   1, 0, "flash_off2");
        cyc(0, 2'b10, 2'b00, 0, 18'h3FFFF, 9'h1FF, 1, 0, "flash_on3");
        cyc(0, 2'b10, 2'b00, 0, 18'h0,     9'h0,   0, 1, "flash_done");
        cyc(0, 2'b10, 2'b00, 0, 18'h0,     9'h0,   0, 0, "flash_hold1");
        cyc(0, 2'b10, 2'b00, 0, 18'h0,     9'h0,   0, 0, "flash_hold2");

        // SWEEP with 4 steps, then HOLD with the mode still selected
        cyc(0, 2'b11, 2'b00, 0, 18'h2AAAA, 9'h0AA, 1, 0, "sweep_f0");
        cyc(0, 2'b11, 2'b00, 0, 18'h15555, 9'h155, 1, 0, "sweep_f1");
        cyc(0, 2'b11, 2'b00, 0, 18'h2AAAA, 9'h0AA, 1, 0, "sweep_f2");
        cyc(0, 2'b11, 2'b00, 0, 18'h15555, 9'h155, 1, 0, "sweep_f3");
        cyc(0, 2'b11, 2'b00, 0, 18'h0,     9'h0,   0, 1, "sweep_done");
        for (int i = 0; i < 3; i++) cyc(0, 2'b11, 2'b00, 0, 18'h0, 9'h0, 0, 0, "sweep_hold");

        // Mid-FLASH switch to SWEEP: no done pulse; then reset mid-SWEEP
        cyc(0, 2'b10, 2'b00, 0, 18'h3FFFF, 9'h1FF, 1, 0, "mid_flash_on");
        cyc(0, 2'b10, 2'b00, 0, 18'h0,     9'h0,   1, 0, "mid_flash_off");
        cyc(0, 2'b11, 2'b00, 0, 18'h2AAAA, 9'h0AA, 1, 0, "switch_sweep");
        cyc(0, 2'b11, 2'b00, 0, 18'h15555, 9'h155, 1, 0, "switch_sweep_f1");
        cyc(1, 2'b11, 2'b00, 0, 18'h0,     9'h0,   0, 0, "mid_sweep_reset");
        cyc(0, 2'b11, 2'b00, 0, 18'h2AAAA, 9'h0AA, 1, 0, "sweep_after_reset");

        // Divided instance: each chase frame lasts 4 clk
        for (int i = 0; i < 4; i++) cyc(0, 2'b00, 2'b01, 1, 18'h00780, 9'h155, 1, 0, "div_f0");
        for (int i = 0; i < 4; i++) cyc(0, 2'b00, 2'b01, 1, 18'h00CC0, 9'h0AA, 1, 0, "div_f1");
        cyc(0, 2'b00, 2'b01, 1, 18'h01860, 9'h155, 1, 0, "div_f2");

        // Let the monitor drain the queue, bounded
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clk);
            #2;
        end
        if (exp_q.size() != 0) begin
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
            $fatal(1, "scoreboard did not drain");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
